// File: rtl/eth_pkg.sv
// Shared 10G receive-path definitions: block-lock states, sync header codes,
// default 10G block-lock parameters and the header classification helper.
package eth_pkg;

  typedef enum logic [1:0] {
    HUNT      = 2'd0,
    SLIP_WAIT = 2'd1,
    LOCKED    = 2'd2
  } lock_state_t;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  localparam int DEF_LOCK_COUNT  = 64;
  localparam int DEF_WINDOW_HDRS = 1024;
  localparam int DEF_UNLOCK_BAD  = 16;
  localparam int DEF_SLIP_WAIT   = 32;
  localparam int DEF_BER_WINDOW  = 19531;
  localparam int DEF_BER_THRESH  = 16;

  // Same result as hdr[0] ^ hdr[1]: only the two legal sync codes pass.
  function automatic logic hdr_is_valid(input logic [1:0] hdr);
    return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
  endfunction

endpackage

// File: rtl/qsfp_rx_ber_mon.sv
// BER monitor: counts invalid headers per fixed cycle window, flags high BER one cycle after threshold.
// No backpressure; held cleared whenever enable (block lock) is low.
module qsfp_rx_ber_mon
  import eth_pkg::*;
#(
  parameter int BER_WINDOW = DEF_BER_WINDOW,
  parameter int BER_THRESH = DEF_BER_THRESH
) (
  input  logic clock,
  input  logic resetn,
  input  logic enable,
  input  logic hdr_bad,
  output logic high_ber
);

  localparam int TIMER_W = $clog2(BER_WINDOW + 1);
  localparam int CNT_W   = $clog2(BER_THRESH + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(BER_WINDOW - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = CNT_W'(BER_THRESH);

  logic [TIMER_W-1:0] ber_timer;
  logic [CNT_W-1:0]   ber_cnt;
  logic               wrap;
  logic               at_thresh;

  assign wrap      = (ber_timer == TIMER_LAST);
  assign at_thresh = (ber_cnt == CNT_MAX);

  always_ff @(posedge clock) begin
    if (!resetn || !enable) begin
      ber_timer <= '0;
      ber_cnt   <= '0;
      high_ber  <= 1'b0;
    end else begin
      ber_timer <= wrap ? '0 : ber_timer + 1'b1;
      // The wrap-cycle header belongs to the window that is just starting.
      if (wrap) begin
        ber_cnt <= CNT_W'(hdr_bad);
      end else if (hdr_bad && !at_thresh) begin
        ber_cnt <= ber_cnt + 1'b1;
      end
      if (at_thresh) begin
        high_ber <= 1'b1;
      end else if (wrap) begin
        high_ber <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/qsfp_rx_block_lock.sv
// 64b/66b block lock: slips the gearbox until sync headers align, then tracks loss of lock, BER and header errors.
// Outputs registered one cycle after the causing header; no backpressure, every rx_hdr_valid cycle is consumed.
module qsfp_rx_block_lock
  import eth_pkg::lock_state_t, eth_pkg::hdr_is_valid;
#(
  parameter int LOCK_COUNT  = eth_pkg::DEF_LOCK_COUNT,
  parameter int WINDOW_HDRS = eth_pkg::DEF_WINDOW_HDRS,
  parameter int UNLOCK_BAD  = eth_pkg::DEF_UNLOCK_BAD,
  parameter int SLIP_WAIT   = eth_pkg::DEF_SLIP_WAIT,
  parameter int BER_WINDOW  = eth_pkg::DEF_BER_WINDOW,
  parameter int BER_THRESH  = eth_pkg::DEF_BER_THRESH
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [1:0]  rx_hdr,
  input  logic        rx_hdr_valid,
  output logic        rx_bitslip,
  output logic        rx_block_lock,
  output logic        rx_high_ber,
  output logic [15:0] rx_error_count,
  input  logic        rx_error_clear
);

  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam int WAIT_W = $clog2(SLIP_WAIT + 1);
  localparam int HDR_W  = $clog2(WINDOW_HDRS + 1);
  localparam int BAD_W  = $clog2(UNLOCK_BAD + 1);

  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_COUNT - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);
  localparam logic [HDR_W-1:0]  HDR_LAST  = HDR_W'(WINDOW_HDRS - 1);
  localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(UNLOCK_BAD - 1);
  localparam logic [15:0]       ERR_MAX   = 16'hFFFF;

  lock_state_t       state;
  lock_state_t       state_nxt;
  logic [GOOD_W-1:0] good_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [HDR_W-1:0]  hdr_cnt;
  logic [BAD_W-1:0]  bad_cnt;
  logic [15:0]       err_cnt;
  logic              hdr_good;
  logic              hdr_bad;
  logic              locked;
  logic              slip_nxt;
  logic              lock_nxt;

  assign hdr_good = rx_hdr_valid &&  hdr_is_valid(rx_hdr);
  assign hdr_bad  = rx_hdr_valid && !hdr_is_valid(rx_hdr);
  assign locked   = (state == eth_pkg::LOCKED);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= eth_pkg::HUNT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      eth_pkg::HUNT: begin
        if (hdr_bad) begin
          state_nxt = eth_pkg::SLIP_WAIT;
        end else if (hdr_good && good_cnt == GOOD_LAST) begin
          state_nxt = eth_pkg::LOCKED;
        end
      end
      eth_pkg::SLIP_WAIT: begin
        if (wait_cnt == WAIT_LAST) begin
          state_nxt = eth_pkg::HUNT;
        end
      end
      eth_pkg::LOCKED: begin
        // Unlock beats a coincident window close.
        if (hdr_bad && bad_cnt == BAD_LAST) begin
          state_nxt = eth_pkg::SLIP_WAIT;
        end
      end
      default: state_nxt = eth_pkg::HUNT;
    endcase
  end

  always_comb begin
    slip_nxt = 1'b0;
    lock_nxt = 1'b0;
    if (state_nxt == eth_pkg::SLIP_WAIT && state != eth_pkg::SLIP_WAIT) begin
      slip_nxt = 1'b1;
    end
    if (state_nxt == eth_pkg::LOCKED) begin
      lock_nxt = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      rx_bitslip    <= 1'b0;
      rx_block_lock <= 1'b0;
    end else begin
      rx_bitslip    <= slip_nxt;
      rx_block_lock <= lock_nxt;
    end
  end

  // wait_cnt wraps to zero on leaving SLIP_WAIT, so every slip wait starts from 0.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      good_cnt <= '0;
      wait_cnt <= '0;
      hdr_cnt  <= '0;
      bad_cnt  <= '0;
    end else begin
      case (state)
        eth_pkg::HUNT: begin
          if (hdr_bad || state_nxt == eth_pkg::LOCKED) begin
            good_cnt <= '0;
          end else if (hdr_good) begin
            good_cnt <= good_cnt + 1'b1;
          end
          if (state_nxt == eth_pkg::LOCKED) begin
            hdr_cnt <= '0;
            bad_cnt <= '0;
          end
        end
        eth_pkg::SLIP_WAIT: begin
          good_cnt <= '0;
          wait_cnt <= (wait_cnt == WAIT_LAST) ? '0 : wait_cnt + 1'b1;
        end
        eth_pkg::LOCKED: begin
          if (rx_hdr_valid) begin
            if (state_nxt != eth_pkg::LOCKED || hdr_cnt == HDR_LAST) begin
              hdr_cnt <= '0;
              bad_cnt <= '0;
            end else begin
              hdr_cnt <= hdr_cnt + 1'b1;
              bad_cnt <= bad_cnt + BAD_W'(hdr_bad);
            end
          end
        end
        default: begin
          good_cnt <= '0;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn || rx_error_clear) begin
      err_cnt <= '0;
    end else if (locked && hdr_bad && err_cnt != ERR_MAX) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

  assign rx_error_count = err_cnt;

  qsfp_rx_ber_mon #(
    .BER_WINDOW (BER_WINDOW),
    .BER_THRESH (BER_THRESH)
  ) u_ber_mon (
    .clock    (clock),
    .resetn   (resetn),
    .enable   (locked),
    .hdr_bad  (hdr_bad),
    .high_ber (rx_high_ber)
  );

endmodule

// File: tb/tb_qsfp_rx_block_lock.sv
// Directed bench for qsfp_rx_block_lock: expected outputs are queued with each
// stimulus step and compared right after the clock edge that produces them.
module tb_qsfp_rx_block_lock;

  logic        clock = 1'b0;
  logic        resetn;
  logic [1:0]  rx_hdr;
  logic        rx_hdr_valid;
  logic        rx_bitslip;
  logic        rx_block_lock;
  logic        rx_high_ber;
  logic [15:0] rx_error_count;
  logic        rx_error_clear;

  typedef struct {
    string       tag;
    int          sel;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   slip_count = 0;
  int   last_slip = 0;
  int   min_gap = 1000000;
  logic bad;

  qsfp_rx_block_lock #(
    .LOCK_COUNT  (64),
    .WINDOW_HDRS (1024),
    .UNLOCK_BAD  (16),
    .SLIP_WAIT   (32),
    .BER_WINDOW  (200),
    .BER_THRESH  (16)
  ) dut (
    .clock          (clock),
    .resetn         (resetn),
    .rx_hdr         (rx_hdr),
    .rx_hdr_valid   (rx_hdr_valid),
    .rx_bitslip     (rx_bitslip),
    .rx_block_lock  (rx_block_lock),
    .rx_high_ber    (rx_high_ber),
    .rx_error_count (rx_error_count),
    .rx_error_clear (rx_error_clear)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    cyc++;
    if (rx_bitslip === 1'b1) begin
      if (slip_count > 0 && (cyc - last_slip) < min_gap) min_gap = cyc - last_slip;
      last_slip = cyc;
      slip_count++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish expected finish before 1000000");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [15:0] observe(input int sel);
    case (sel)
      0:       return {15'd0, rx_bitslip};
      1:       return {15'd0, rx_block_lock};
      2:       return {15'd0, rx_high_ber};
      default: return rx_error_count;
    endcase
  endfunction

  task automatic expect_out(input string tag, input int sel, input logic [15:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t        e;
    logic [15:0] obs;
    @(posedge clock);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      obs = observe(e.sel);
      checks++;
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] h);
    rx_hdr_valid = v;
    rx_hdr       = h;
    tick();
  endtask

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    resetn = 1'b0;
    rx_hdr = 2'b00;
    rx_hdr_valid = 1'b0;
    rx_error_clear = 1'b0;

    // Reset with random headers.
    for (int i = 0; i < 4; i++) begin
      expect_out("rst_slip", 0, 16'd0);
      expect_out("rst_lock", 1, 16'd0);
      expect_out("rst_ber", 2, 16'd0);
      expect_out("rst_err", 3, 16'd0);
      drive(1'b1, 2'($urandom_range(0, 3)));
    end

    // Lock acquisition: one bad header, 32 ignored cycles, 64 good headers.
    resetn = 1'b1;
    expect_out("acq_slip_pulse", 0, 16'd1);
    expect_out("acq_lock_low", 1, 16'd0);
    drive(1'b1, 2'b11);
    for (int i = 0; i < 32; i++) begin
      expect_out("wait_slip", 0, 16'd0);
      expect_out("wait_lock", 1, 16'd0);
      drive(1'b1, (i % 2 == 0) ? 2'b00 : 2'b11);
    end
    for (int i = 0; i < 64; i++) begin
      expect_out("acq_slip", 0, 16'd0);
      expect_out("acq_lock", 1, (i == 63) ? 16'd1 : 16'd0);
      drive(1'b1, (i % 2 == 0) ? 2'b01 : 2'b10);
    end

    // 15 bad headers in one 1024-header window keep lock.
    for (int i = 0; i < 1024; i++) begin
      bad = (i % 64 == 10) && (i < 15 * 64);
      if (i == 10) expect_out("lol_err_first", 3, 16'd1);
      if (i == 1023) begin
        expect_out("lol15_lock", 1, 16'd1);
        expect_out("lol15_err", 3, 16'd15);
        expect_out("lol15_ber", 2, 16'd0);
      end
      drive(1'b1, bad ? ((i % 128 == 10) ? 2'b11 : 2'b00) : ((i % 2 == 0) ? 2'b01 : 2'b10));
    end
    // 16 bad headers in the fresh window drop lock.
    for (int i = 0; i < 16; i++) begin
      expect_out("lol16_lock", 1, (i == 15) ? 16'd0 : 16'd1);
      expect_out("lol16_slip", 0, (i == 15) ? 16'd1 : 16'd0);
      if (i == 15) expect_out("lol16_err", 3, 16'd31);
      drive(1'b1, 2'b00);
    end
    for (int i = 0; i < 32; i++) begin
      expect_out("wait2_slip", 0, 16'd0);
      drive(1'b1, 2'b11);
    end

    // Gated headers: 64 valid events over 128 cycles.
    for (int i = 0; i < 128; i++) begin
      if (i == 126) expect_out("gate_lock_early", 1, 16'd0);
      if (i == 127) expect_out("gate_lock", 1, 16'd1);
      drive(i % 2 == 1, (i % 2 == 1) ? ((i % 4 == 1) ? 2'b01 : 2'b10) : 2'b11);
    end

    // High BER: 16 bad headers across a lock-window boundary inside one BER window.
    for (int k = 1; k <= 1410; k++) begin
      bad = (k >= 1010 && k <= 1017) || (k >= 1030 && k <= 1037);
      if (k == 1000) expect_out("ber_clean", 2, 16'd0);
      if (k == 1037) expect_out("ber_not_yet", 2, 16'd0);
      if (k == 1038) expect_out("ber_set", 2, 16'd1);
      if (k == 1190) expect_out("ber_hold", 2, 16'd1);
      if (k == 1390) expect_out("ber_until_wrap", 2, 16'd1);
      if (k == 1410) begin
        expect_out("ber_cleared", 2, 16'd0);
        expect_out("ber_lock_held", 1, 16'd1);
        expect_out("ber_err", 3, 16'd47);
      end
      drive(1'b1, bad ? 2'b00 : ((k % 2 == 0) ? 2'b01 : 2'b10));
    end

    // Error counter saturation and clear priority.
    force dut.err_cnt = 16'hFFFD;
    #1;
    release dut.err_cnt;
    expect_out("sat_fffe", 3, 16'hFFFE);
    drive(1'b1, 2'b00);
    expect_out("sat_ffff", 3, 16'hFFFF);
    drive(1'b1, 2'b11);
    expect_out("sat_hold", 3, 16'hFFFF);
    drive(1'b1, 2'b00);
    rx_error_clear = 1'b1;
    expect_out("clr_wins", 3, 16'd0);
    drive(1'b1, 2'b00);
    rx_error_clear = 1'b0;
    expect_out("post_clr_inc", 3, 16'd1);
    expect_out("post_clr_lock", 1, 16'd1);
    drive(1'b1, 2'b00);

    // Reset mid-lock.
    resetn = 1'b0;
    expect_out("mid_rst_lock", 1, 16'd0);
    expect_out("mid_rst_err", 3, 16'd0);
    expect_out("mid_rst_slip", 0, 16'd0);
    drive(1'b1, 2'b01);
    resetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      expect_out("relock_wait", 1, 16'd0);
      drive(1'b1, (i % 2 == 0) ? 2'b10 : 2'b01);
    end

    check_val("slip_count", slip_count, 2);
    check_val("slip_gap_ok", (min_gap >= 33) ? 1 : 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
